// File: rtl/sepe_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sepe_fetch_stage                                             |
// | Description : Fetch stage between the SEPE instruction FIFO and decode.    |
// |               Pulls words from the FIFO read port into a small circular    |
// |               prefetch queue, drops NOP bubbles, and presents the queue    |
// |               head to decode over a valid/ready handshake. Supports flush. |
// |               Optional statistics build: define SEPE_FETCH_STATS_EN to get |
// |               issued/bubble counters; otherwise both read 16'h0000.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sepe_fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        inst_fifo_rd,
  input  logic [31:0] inst_fifo_rdata,
  input  logic        flush,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [15:0] issued_cnt,
  output logic [15:0] bubble_cnt
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push;
  logic             w_pop;
  logic             w_rdata_nop;

  // Read request, enqueue/dequeue qualifiers and the decode-facing view of the head
  always_comb begin
    w_rdata_nop  = (inst_fifo_rdata == NOP_INSN);
    // No full-queue bypass: a pop this cycle does not open a slot until next cycle
    inst_fifo_rd = rstn & ~flush & (count_q < FULL_CNT);
    w_push       = inst_fifo_rd & ~w_rdata_nop;
    dec_valid    = (count_q != '0);
    w_pop        = dec_valid & dec_ready & ~flush;
    dec_inst     = dec_valid ? mem_q[rd_ptr_q] : NOP_INSN;
  end

  // Next-state for pointers and occupancy; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; not reset because dec_inst is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= inst_fifo_rdata;
  end

`ifdef SEPE_FETCH_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] bubble_q, bubble_d;

  // Issued count wraps; bubble count saturates so long idle stretches stay readable
  always_comb begin
    issued_d = issued_q + {15'd0, w_pop};
    bubble_d = bubble_q;
    if (inst_fifo_rd && w_rdata_nop && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  // Statistics registers, cleared only by reset (flush leaves them alone)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issued_q <= '0;
      bubble_q <= '0;
    end else begin
      issued_q <= issued_d;
      bubble_q <= bubble_d;
    end
  end

  assign issued_cnt = issued_q;
  assign bubble_cnt = bubble_q;
`else
  assign issued_cnt = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sepe_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sepe_fetch_stage                                          |
// | Description : Self-checking bench for sepe_fetch_stage. A source queue     |
// |               emulates the SEPE FIFO; a reference model of the prefetch    |
// |               queue predicts every decode-side output each cycle.          |
// |               Honours SEPE_FETCH_STATS_EN for the statistics outputs.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sepe_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  logic        clk;
  logic        rstn;
  logic        inst_fifo_rd;
  logic [31:0] inst_fifo_rdata;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [15:0] issued_cnt;
  logic [15:0] bubble_cnt;

  sepe_fetch_stage #(.DEPTH(DEPTH), .NOP_INSN(NOP_INSN)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .inst_fifo_rd    (inst_fifo_rd),
    .inst_fifo_rdata (inst_fifo_rdata),
    .flush           (flush),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .issued_cnt      (issued_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFO contents and whether its head is currently on rdata
  logic [31:0] src_q[$];
  bit          src_shown = 1'b0;

  // Reference model: expected prefetch queue contents and statistics
  logic [31:0] exp_q[$];
  int          m_issued = 0;
  int          m_bubble = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == NOP_INSN) w = 32'h00A00093;
    return w;
  endfunction

  // Present the next stimulus shortly after the rising edge
  task automatic step(input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    dec_ready = rdy;
    flush     = fl;
    src_shown = (src_q.size() > 0);
    inst_fifo_rdata = src_shown ? src_q[0] : NOP_INSN;
  endtask

  // Source FIFO consumes its head whenever the stage reads it
  always @(negedge clk) begin
    if (inst_fifo_rd && src_shown) begin
      void'(src_q.pop_front());
      src_shown = 1'b0;
    end
  end

  // Monitor: compare DUT outputs against the model, then advance the model
  always @(negedge clk) begin
    logic        e_rd;
    logic        e_valid;
    logic [31:0] e_inst;
    if (mon_en) begin
      if (!rstn) begin
        exp_q.delete();
        m_issued = 0;
        m_bubble = 0;
      end
      e_rd    = rstn && !flush && (exp_q.size() < DEPTH);
      e_valid = (exp_q.size() != 0);
      e_inst  = e_valid ? exp_q[0] : NOP_INSN;
      chk("inst_fifo_rd", {31'd0, inst_fifo_rd}, {31'd0, e_rd});
      chk("dec_valid",    {31'd0, dec_valid},    {31'd0, e_valid});
      chk("dec_inst",     dec_inst,              e_inst);
`ifdef SEPE_FETCH_STATS_EN
      chk("issued_cnt", {16'd0, issued_cnt}, 32'(m_issued % 65536));
      chk("bubble_cnt", {16'd0, bubble_cnt}, 32'(m_bubble));
`else
      chk("issued_cnt", {16'd0, issued_cnt}, 32'd0);
      chk("bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
`endif
      if (rstn) begin
        if (flush) begin
          exp_q.delete();
        end else begin
          if (e_valid && dec_ready) begin
            void'(exp_q.pop_front());
            m_issued++;
          end
          if (e_rd) begin
            if (inst_fifo_rdata != NOP_INSN) exp_q.push_back(inst_fifo_rdata);
            else if (m_bubble < 65535) m_bubble++;
          end
        end
      end
    end
  end

  initial begin
    rstn            = 1'b0;
    flush           = 1'b0;
    dec_ready       = 1'b0;
    inst_fifo_rdata = NOP_INSN;
    mon_en          = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Empty FIFO: bubbles only
    repeat (5) step(1'b1, 1'b0);

    // Three back-to-back instructions with decode always ready
    src_q.push_back(32'h00A00093);
    src_q.push_back(32'h00B00113);
    src_q.push_back(32'h00C00193);
    repeat (6) step(1'b1, 1'b0);

    // Fill to full with decode stalled, then drain
    for (int i = 0; i < 6; i++) src_q.push_back(32'h10000000 + 32'(i));
    repeat (7) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);

    // Flush with three entries queued and a real word on rdata
    for (int i = 0; i < 3; i++) src_q.push_back(32'h20000000 + 32'(i));
    repeat (4) step(1'b0, 1'b0);
    src_q.push_back(32'h2000AAAA);
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);

    // Asynchronous reset between edges with two entries queued
    src_q.push_back(32'h30000001);
    src_q.push_back(32'h30000002);
    repeat (3) step(1'b0, 1'b0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("async_rst_inst",  dec_inst,           NOP_INSN);
    chk("async_rst_rd",    {31'd0, inst_fifo_rd}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    src_q.push_back(32'h30000003);
    repeat (4) step(1'b1, 1'b0);

    // Randomised traffic with stalls and occasional flushes
    for (int i = 0; i < 3000; i++) begin
      if (($urandom_range(0, 99) < 60) && (src_q.size() < 8)) src_q.push_back(rand_word());
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
    end

`ifdef SEPE_FETCH_STATS_EN
    // Long idle stretch to drive the bubble counter into saturation
    src_q.delete();
    repeat (66000) step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("bubble_saturated", {16'd0, bubble_cnt}, 32'h0000FFFF);
`endif

    repeat (3) step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sepe_fetch_stage.md
# sepe_fetch_stage

Downstream consumer of the SEPE instruction FIFO. It pulls instructions from the FIFO's `inst_fifo_rd`/`inst_fifo_rdata` read port into a small local prefetch queue, and drops NOP bubbles (0x00000013) returned on empty. It presents one instruction per cycle to decode over a valid/ready handshake. It also supports a pipeline flush and, optionally, delivery/bubble statistics for QED bring-up.

## Interface
- `DEPTH`, 4 — prefetch queue entries; power of two, ≥2.
- `NOP_INSN`, 32'h00000013 — bubble encoding returned by the FIFO when empty; never enqueued.
- `clk` in 1 — single clock, rising edge.
- `rstn` in 1 — reset, asynchronous, active-low.
- `inst_fifo_rd` out 1 — read strobe to the SEPE FIFO.
- `inst_fifo_rdata` in 32 — FIFO read data, valid in the same cycle as `inst_fifo_rd`; equals `NOP_INSN` when the FIFO is empty.
- `flush` in 1 — discard all queued instructions.
- `dec_valid` out 1 — `dec_inst` holds a real instruction.
- `dec_ready` in 1 — decode accepts `dec_inst` this cycle.
- `dec_inst` out 32 — head instruction; `NOP_INSN` when `dec_valid`=0.
- `issued_cnt` out 16 — instructions accepted by decode (stats build only).
- `bubble_cnt` out 16 — read cycles that returned `NOP_INSN` (stats build only).

## Operation
- State:
  - circular queue of `DEPTH`×32 entries;
  - `wr_ptr`/`rd_ptr`, each log2(`DEPTH`) bits, wrapping naturally;
  - `count`, log2(`DEPTH`)+1 bits.
- `inst_fifo_rd = rstn & ~flush & (count < DEPTH)`. This is combinational and does not depend on `dec_ready`; there is no bypass of a full queue.
- push = `inst_fifo_rd & (inst_fifo_rdata != NOP_INSN)`. On push, write `inst_fifo_rdata` at `wr_ptr`, then `wr_ptr`+1.
- pop = `dec_valid & dec_ready & ~flush`. On pop, `rd_ptr`+1.
- `count` next value:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged. This is legal, including at `count`=`DEPTH`−1.
- `dec_valid = (count != 0)`.
- `dec_inst` = entry at `rd_ptr` when valid, else `NOP_INSN`.
- Handshake: once `dec_valid` is high, `dec_inst` is stable until popped or flushed.
- Flush:
  - In the flush cycle: `wr_ptr`, `rd_ptr` and `count` → 0; no read, no pop, no push.
  - `dec_valid` drops on the next edge.
- A FIFO that returns NOP is treated as empty. The read retries every cycle while space remains.

## Timing
- Reset (async assert): ptrs, `count`, counters → 0.
  - `dec_valid`=0, `dec_inst`=`NOP_INSN`.
  - `inst_fifo_rd`=0 while `rstn`=0.
- Reset mid-operation: queue contents are lost. Entry RAM is not cleared, but it is not observable because `dec_inst` is masked.
- Latency: a non-NOP read in cycle N gives `dec_valid`=1 with that instruction in cycle N+1.
- Throughput: one instruction per cycle sustained with `dec_ready`=1, including a queue of 1 entry (simultaneous push/pop).
- Full: at `count`=`DEPTH`, `inst_fifo_rd`=0 even if `dec_ready`=1 that cycle. The read resumes the cycle after the pop (one bubble at full).
- Order: strict FIFO; entries are never reordered or duplicated.

## Configuration
- `SEPE_FETCH_STATS_EN` defined:
  - `issued_cnt` increments on every pop and wraps modulo 2^16.
  - `bubble_cnt` increments when `inst_fifo_rd`=1 and `inst_fifo_rdata`=`NOP_INSN`, and saturates at 16'hFFFF.
  - Both counters clear on reset only; flush does not clear them.
- Not defined: both outputs are tied to 16'h0000 and no counter flops are built.

## Test plan
- Reset, then feed `inst_fifo_rdata`=0x00000013 for 5 cycles → `inst_fifo_rd`=1 each cycle, `dec_valid`=0, `bubble_cnt`=5 (stats), `issued_cnt`=0.
- Feed 0x00A00093, 0x00B00113, 0x00C00193 back-to-back with `dec_ready`=1 → same three values on `dec_inst` in cycles N+1..N+3, `issued_cnt`=3.
- `dec_ready`=0 with 6 non-NOP words offered → first 4 enqueued; `inst_fifo_rd`=0 from the cycle `count`=4; `dec_inst` holds word 0. Raise `dec_ready` → words 0–3 drain in order, then word 4 follows.
- Queue holding 3 entries, assert `flush` for 1 cycle with a non-NOP on `rdata` → `inst_fifo_rd`=0 that cycle, nothing pushed, `dec_valid`=0 next cycle, `issued_cnt` unchanged.
- Deassert `rstn` asynchronously between edges with 2 entries queued → `dec_valid`=0 and `dec_inst`=0x00000013 immediately. After release, the first non-NOP read appears one cycle later.
- Stats: run 70000 NOP read cycles → `bubble_cnt` saturates at 0xFFFF. Pop 65537 instructions → `issued_cnt`=1. Without `SEPE_FETCH_STATS_EN`, both read 0 throughout.
